// File: rtl/pid_pkg.sv
// Shared constants, FSM encoding and saturation helper for the multiplexed PID core.
package pid_pkg;

  localparam int CHN_WIDTH = 3;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;
  localparam int INTEG_W   = 24;
  localparam int COEF_W    = 16;
  localparam int MUL_W     = 25;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERR  = 3'd1;
  localparam logic [2:0] S_P    = 3'd2;
  localparam logic [2:0] S_I    = 3'd3;
  localparam logic [2:0] S_D    = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  // Symmetric clamp to +/-lim; callers truncate the result to their own width.
  function automatic logic signed [ACC_W-1:0] sat_sym(input logic signed [ACC_W-1:0] v,
                                                      input logic signed [ACC_W-1:0] lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Shared signed 16x25 multiply with clear-or-accumulate into a registered 40-bit sum.
module pid_mac
  import pid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [MUL_W-1:0]  x,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [COEF_W+MUL_W-1:0] prod;
  logic signed [ACC_W-1:0]        prod_t;

  assign prod   = coef * x;
  assign prod_t = signed'(prod[ACC_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? prod_t : acc + prod_t;
    end
  end

endmodule

// File: rtl/pid_mux_core.sv
// Time-multiplexed PID controller sweeping NUM_CHN channels through one shared MAC.
// Define PID_DERIV_EN to include the derivative step (5-cycle channel slot instead of 4).
module pid_mux_core #(
  parameter int                DATA_WIDTH = 16,
  parameter int                NUM_CHN    = 4,
  parameter int                CHN_WIDTH  = pid_pkg::CHN_WIDTH,
  parameter logic signed [15:0] KP        = 16'sd256,
  parameter logic signed [15:0] KI        = 16'sd0,
  parameter logic signed [15:0] KD        = 16'sd0,
  parameter int                FRAC_BITS  = pid_pkg::FRAC_BITS,
  parameter int                OUT_MAX    = 1500,
  parameter int                INTEG_MAX  = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sp_valid_i,
  input  logic [CHN_WIDTH-1:0]         sp_chn_i,
  input  logic signed [DATA_WIDTH-1:0] sp_data_i,
  input  logic                         y_valid_i,
  input  logic [CHN_WIDTH-1:0]         y_chn_i,
  input  logic signed [DATA_WIDTH-1:0] y_data_i,
  output logic                         u_valid_o,
  output logic [CHN_WIDTH-1:0]         u_chn_o,
  output logic signed [DATA_WIDTH-1:0] u_data_o,
  output logic                         busy_o,
  output logic                         overrun_o
);
  import pid_pkg::*;

  localparam int ERR_W = DATA_WIDTH + 1;
  localparam int IDX_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam logic [CHN_WIDTH-1:0] LAST_CH = CHN_WIDTH'(NUM_CHN - 1);

  logic [2:0]                  state;
  logic [CHN_WIDTH-1:0]        ch;
  logic [IDX_W-1:0]            ch_idx;
  logic signed [DATA_WIDTH-1:0] sp_r    [NUM_CHN];
  logic signed [DATA_WIDTH-1:0] y_r     [NUM_CHN];
  logic signed [INTEG_W-1:0]   integ_r [NUM_CHN];
  logic signed [ERR_W-1:0]     e_now;
  logic signed [ERR_W-1:0]     e_p0;
  logic signed [ACC_W-1:0]     integ_sum;
  logic signed [INTEG_W-1:0]   integ_new;
  logic                        mac_en;
  logic                        mac_clr;
  logic signed [COEF_W-1:0]    mac_coef;
  logic signed [MUL_W-1:0]     mac_x;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_sh;
  logic signed [DATA_WIDTH-1:0] u_next;

`ifdef PID_DERIV_EN
  logic signed [ERR_W-1:0]     eprev_r [NUM_CHN];
  logic signed [ERR_W:0]       de;
  assign de = (ERR_W+1)'(e_p0) - (ERR_W+1)'(eprev_r[ch_idx]);
`else
  logic unused_kd;
  assign unused_kd = ^KD;
`endif

  assign ch_idx = ch[IDX_W-1:0];
  assign busy_o = (state != S_IDLE);

  // Writes to channel indices beyond the last channel are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        sp_r[i] <= '0;
        y_r[i]  <= '0;
      end
    end else begin
      if (sp_valid_i && (sp_chn_i <= LAST_CH)) sp_r[sp_chn_i[IDX_W-1:0]] <= sp_data_i;
      if (y_valid_i && (y_chn_i <= LAST_CH))   y_r[y_chn_i[IDX_W-1:0]]   <= y_data_i;
    end
  end

  // Stage p0: error and clamped integrator for the current channel
  assign e_now     = ERR_W'(sp_r[ch_idx]) - ERR_W'(y_r[ch_idx]);
  assign integ_sum = ACC_W'(integ_r[ch_idx]) + ACC_W'(e_now);
  assign integ_new = INTEG_W'(sat_sym(integ_sum, ACC_W'(INTEG_MAX)));

  // Stage p1: one MAC term per state
  always_comb begin
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    mac_coef = '0;
    mac_x    = '0;
    case (state)
      S_P: begin
        mac_en   = 1'b1;
        mac_clr  = 1'b1;
        mac_coef = KP;
        mac_x    = MUL_W'(e_p0);
      end
      S_I: begin
        mac_en   = 1'b1;
        mac_coef = KI;
        mac_x    = MUL_W'(integ_r[ch_idx]);
      end
`ifdef PID_DERIV_EN
      S_D: begin
        mac_en   = 1'b1;
        mac_coef = KD;
        mac_x    = MUL_W'(de);
      end
`endif
      default: ;
    endcase
  end

  pid_mac u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (mac_en),
    .clr  (mac_clr),
    .coef (mac_coef),
    .x    (mac_x),
    .acc  (acc)
  );

  // Stage p2: rescale and saturate the finished accumulator
  assign acc_sh = acc >>> FRAC_BITS;
  assign u_next = DATA_WIDTH'(sat_sym(acc_sh, ACC_W'(OUT_MAX)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      e_p0      <= '0;
      u_valid_o <= 1'b0;
      u_chn_o   <= '0;
      u_data_o  <= '0;
      overrun_o <= 1'b0;
      for (int i = 0; i < NUM_CHN; i++) begin
        integ_r[i] <= '0;
`ifdef PID_DERIV_EN
        eprev_r[i] <= '0;
`endif
      end
    end else begin
      u_valid_o <= 1'b0;
      if (start && state != S_IDLE) overrun_o <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ERR;
            ch    <= '0;
          end
        end
        S_ERR: begin
          e_p0            <= e_now;
          integ_r[ch_idx] <= integ_new;
          state           <= S_P;
        end
        S_P: state <= S_I;
`ifdef PID_DERIV_EN
        S_I: state <= S_D;
        S_D: begin
          eprev_r[ch_idx] <= e_p0;
          state           <= S_OUT;
        end
`else
        S_I: state <= S_OUT;
`endif
        S_OUT: begin
          u_valid_o <= 1'b1;
          u_chn_o   <= ch;
          u_data_o  <= u_next;
          if (ch == LAST_CH) begin
            state <= S_IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
